// File: rtl/video_shift_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : video_shift_tap_ctrl_if
// Brief   : Pixel-in, line-RAM and tap-out signal bundle of the line-delay
//           sequencer. The slave modport is the sequencer's view; the master
//           modport is the view of whatever surrounds it.
// Revision: 1.0 - initial release
// ============================================================================
interface video_shift_tap_ctrl_if #(
    parameter int DSIZE = 24,
    parameter int ASIZE = 10,
    parameter int TAPS  = 2
);
    // pixel input
    logic                        in_valid;
    logic                        in_sof;
    logic                        in_eol;
    logic [DSIZE-1:0]            in_data;
    // shared line-RAM port
    logic                        ram_rd_en;
    logic [ASIZE-1:0]            ram_rd_addr;
    logic [TAPS*DSIZE-1:0]       ram_rd_data;
    logic                        ram_wr_en;
    logic [ASIZE-1:0]            ram_wr_addr;
    logic [TAPS*DSIZE-1:0]       ram_wr_data;
    // tap output and status
    logic                        out_valid;
    logic [(TAPS+1)*DSIZE-1:0]   out_data;
    logic [TAPS:0]               out_tap_vld;
    logic                        out_sof;
    logic                        out_eol;
    logic [ASIZE:0]              line_len;
    logic                        line_err;

    modport slave (
        input  in_valid, in_sof, in_eol, in_data, ram_rd_data,
        output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        output out_valid, out_data, out_tap_vld, out_sof, out_eol,
        output line_len, line_err
    );

    modport master (
        output in_valid, in_sof, in_eol, in_data, ram_rd_data,
        input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        input  out_valid, out_data, out_tap_vld, out_sof, out_eol,
        input  line_len, line_err
    );
endinterface
`default_nettype wire

// File: rtl/video_shift_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : video_shift_tap_ctrl
// Brief   : Sequencer for a chain of TAPS line RAMs sharing one column
//           address. Each pixel goes into RAM 0 while every RAM's old word
//           at that column moves one RAM down the chain; the current pixel
//           and the TAPS pixels vertically above it leave two clocks later.
// Revision: 1.0 - initial release
// ============================================================================
module video_shift_tap_ctrl #(
    parameter int DSIZE = 24,
    parameter int ASIZE = 10,
    parameter int TAPS  = 2
) (
    input  wire logic             clock,
    input  wire logic             rst_n,
    video_shift_tap_ctrl_if.slave bus
);
    localparam int               LSW       = $clog2(TAPS + 1);
    localparam logic [LSW-1:0]   c_TAPS_LS = LSW'(TAPS);
    localparam logic [ASIZE-1:0] c_COL_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // line / frame tracking
    state_t                      r_state;
    logic [ASIZE-1:0]            r_col;
    logic                        r_wrap;        // current line passed 2^ASIZE pixels
    logic [LSW-1:0]              r_lines_seen;
    logic [ASIZE:0]              r_line_len;
    logic                        r_line_err;
    // stage 1: RAM read in flight, write issued
    logic                        r_s1_valid;
    logic                        r_s1_sof;
    logic                        r_s1_eol;
    logic [ASIZE-1:0]            r_s1_col;
    logic [DSIZE-1:0]            r_s1_data;
    logic [TAPS:0]               r_s1_tap;
    // stage 2: tap output
    logic                        r_out_valid;
    logic                        r_out_sof;
    logic                        r_out_eol;
    logic [(TAPS+1)*DSIZE-1:0]   r_out_data;
    logic [TAPS:0]               r_out_tap;

    logic                        w_sof;
    logic                        w_accept;
    logic [ASIZE-1:0]            w_col_cur;
    logic                        w_wrap_cur;
    logic [LSW-1:0]              w_ls_cur;
    logic [LSW-1:0]              w_ls_next;
    logic                        w_err_base;
    logic                        w_err_set;
    logic [TAPS:0]               w_tap;

    // A sof pixel restarts the frame, so its own column/line state is the reset one.
    assign w_sof      = bus.in_valid & bus.in_sof;
    assign w_accept   = bus.in_valid & (bus.in_sof | (r_state != ST_IDLE));
    assign w_col_cur  = w_sof ? '0 : r_col;
    assign w_wrap_cur = w_sof ? 1'b0 : r_wrap;
    assign w_ls_cur   = w_sof ? '0 : r_lines_seen;
    assign w_ls_next  = (bus.in_eol && (w_ls_cur != c_TAPS_LS)) ? (w_ls_cur + LSW'(1)) : w_ls_cur;
    assign w_err_base = w_sof ? 1'b0 : r_line_err;
    // Overlong line (about to wrap) or 1-pixel line (read/write collide next pixel).
    assign w_err_set  = ((w_col_cur == c_COL_MAX) && !bus.in_eol) ||
                        ((w_col_cur == '0) && bus.in_eol);

    // Tap k holds real data only once k lines of this frame have completed.
    assign w_tap[0] = 1'b1;
    for (genvar k = 1; k <= TAPS; k++) begin : g_tap
        assign w_tap[k] = (w_ls_cur >= LSW'(k));
    end

    // Read side is combinational so the RAM q arrives exactly one clock later.
    assign bus.ram_rd_en   = w_accept;
    assign bus.ram_rd_addr = w_col_cur;
    assign bus.ram_wr_en   = r_s1_valid;
    assign bus.ram_wr_addr = r_s1_col;

    // Chain write: RAM k receives the word just read from RAM k-1 at the same column.
    if (TAPS > 1) begin : g_chain_multi
        assign bus.ram_wr_data = {bus.ram_rd_data[(TAPS-1)*DSIZE-1:0], r_s1_data};
    end else begin : g_chain_single
        assign bus.ram_wr_data = r_s1_data;
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_sof     = r_out_sof;
    assign bus.out_eol     = r_out_eol;
    assign bus.out_data    = r_out_data;
    assign bus.out_tap_vld = r_out_tap;
    assign bus.line_len    = r_line_len;
    assign bus.line_err    = r_line_err;

    // Frame state, column counter, line length and sticky line error.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_wrap       <= 1'b0;
            r_lines_seen <= '0;
            r_line_len   <= '0;
            r_line_err   <= 1'b0;
        end else if (w_accept) begin
            r_state      <= (w_ls_next == c_TAPS_LS) ? ST_RUN : ST_FILL;
            r_lines_seen <= w_ls_next;
            r_line_err   <= w_err_base | w_err_set;
            if (bus.in_eol) begin
                r_col      <= '0;
                r_wrap     <= 1'b0;
                r_line_len <= {w_wrap_cur, w_col_cur} + (ASIZE+1)'(1);
            end else begin
                r_col      <= w_col_cur + ASIZE'(1);
                r_wrap     <= w_wrap_cur | (w_col_cur == c_COL_MAX);
            end
        end
    end

    // Stage 1: hold the pixel and its tap flags while the RAM read completes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_col   <= '0;
            r_s1_data  <= '0;
            r_s1_tap   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sof  <= bus.in_sof;
                r_s1_eol  <= bus.in_eol;
                r_s1_col  <= w_col_cur;
                r_s1_data <= bus.in_data;
                r_s1_tap  <= w_tap;
            end
        end
    end

    // Stage 2: present the current pixel with the column's delayed pixels.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_data  <= '0;
            r_out_tap   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_sof   <= r_s1_valid & r_s1_sof;
            r_out_eol   <= r_s1_valid & r_s1_eol;
            if (r_s1_valid) begin
                r_out_data <= {bus.ram_rd_data, r_s1_data};
                r_out_tap  <= r_s1_tap;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_video_shift_tap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_video_shift_tap_ctrl
// Brief   : Self-checking bench for video_shift_tap_ctrl (TAPS=2, ASIZE=3)
//           with behavioural line RAMs and a frame/line reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_shift_tap_ctrl;
    localparam int DSIZE = 24;
    localparam int ASIZE = 3;
    localparam int TAPS  = 2;
    localparam int NCOL  = 1 << ASIZE;
    localparam int OW    = (TAPS + 1) * DSIZE;
    localparam int NT    = 13;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    video_shift_tap_ctrl_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TAPS(TAPS)) vif();

    video_shift_tap_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TAPS(TAPS)) u_dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    // behavioural line RAMs: registered read, read-before-write
    logic [DSIZE-1:0]      mem [TAPS][NCOL];
    logic [TAPS*DSIZE-1:0] ram_q;
    always @(posedge clock) begin
        for (int k = 0; k < TAPS; k++) begin
            if (vif.ram_rd_en) ram_q[k*DSIZE +: DSIZE] <= mem[k][vif.ram_rd_addr];
            if (vif.ram_wr_en) mem[k][vif.ram_wr_addr] <= vif.ram_wr_data[k*DSIZE +: DSIZE];
        end
    end
    assign vif.ram_rd_data = ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TAPS:0] tap;
        logic          sof;
        logic          eol;
        logic [OW-1:0] data;
        logic [OW-1:0] mask;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    bit               mon_en = 1'b0;
    int               out_cnt = 0;
    int               acc_cnt = 0;

    bit               m_active;
    int               m_line;      // completed lines in current frame
    int               m_pos;       // pixels so far in current line
    bit               m_dirty;     // RAM data unreliable for rest of frame
    logic [DSIZE-1:0] m_pix [4][NCOL];
    bit               m_pv  [4][NCOL];

    task automatic model_reset();
        m_active = 1'b0; m_line = 0; m_pos = 0; m_dirty = 1'b0;
    endtask

    // Expected output: slice k = same column, k lines up, if those lines reached it.
    task automatic model_accept(input logic sof, input logic eol, input logic [DSIZE-1:0] d);
        exp_t e;
        bit   ok;
        if (sof) begin
            m_active = 1'b1; m_line = 0; m_pos = 0; m_dirty = 1'b0;
            for (int c = 0; c < NCOL; c++) m_pv[0][c] = 1'b0;
        end
        e.tap = '0; e.data = '0; e.mask = '0;
        e.sof = sof; e.eol = eol;
        e.tap[0] = 1'b1;
        e.data[DSIZE-1:0] = d;
        e.mask[DSIZE-1:0] = '1;
        for (int k = 1; k <= TAPS; k++) begin
            e.tap[k] = (m_line >= k);
            if (e.tap[k] && !m_dirty && m_pos < NCOL) begin
                ok = 1'b1;
                for (int j = 1; j <= k; j++) if (!m_pv[(m_line - j) & 3][m_pos]) ok = 1'b0;
                if (ok) begin
                    e.data[k*DSIZE +: DSIZE] = m_pix[(m_line - k) & 3][m_pos];
                    e.mask[k*DSIZE +: DSIZE] = '1;
                end
            end
        end
        sb.push_back(e);
        acc_cnt++;
        if (m_pos < NCOL) begin
            m_pix[m_line & 3][m_pos] = d;
            m_pv[m_line & 3][m_pos]  = 1'b1;
        end
        m_pos++;
        if (m_pos == NCOL && !eol) m_dirty = 1'b1;
        if (eol) begin
            if (m_pos == 1) m_dirty = 1'b1;
            m_line++;
            m_pos = 0;
            for (int c = 0; c < NCOL; c++) m_pv[m_line & 3][c] = 1'b0;
        end
    endtask

    // Apply one input cycle; check the combinational read request.
    task automatic drive(input logic v, input logic s, input logic e, input logic [DSIZE-1:0] d);
        logic acc;
        int   ecol;
        vif.in_valid = v; vif.in_sof = s; vif.in_eol = e; vif.in_data = d;
        acc  = v && (s || m_active);
        ecol = (v && s) ? 0 : (m_pos % NCOL);
        #1;
        chk("rd_en", vif.ram_rd_en, acc);
        if (acc) begin
            chk("rd_addr", vif.ram_rd_addr, ecol);
            model_accept(s, e, d);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    // output monitor against the scoreboard
    always @(negedge clock) begin
        if (mon_en && rst_n && vif.out_valid) begin
            out_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got out_valid=1 expected no output");
            end else begin
                mon_e = sb.pop_front();
                chk("out_tap", vif.out_tap_vld, mon_e.tap);
                chk("out_marks", {vif.out_sof, vif.out_eol}, {mon_e.sof, mon_e.eol});
                chk("out_data", vif.out_data & mon_e.mask, mon_e.data & mon_e.mask);
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic             v;
        logic             sof;
        logic             eol;
        logic [DSIZE-1:0] d;
        logic [TAPS:0]    etap;
        logic [OW-1:0]    edata;
        logic [OW-1:0]    emask;
    } vec_t;

    function automatic logic [DSIZE-1:0] pv(input int l, input int c);
        return DSIZE'(32'h10 + l * 4 + c);
    endfunction

    initial begin
        vec_t tbl [NT];
        vec_t t;
        int   n;
        int   base;
        int   o0, a0;
        int   len, nl, lim;
        bit   trunc;

        vif.in_valid = 1'b0; vif.in_sof = 1'b0; vif.in_eol = 1'b0; vif.in_data = '0;
        model_reset();

        // 3 lines x 4 px, one bubble inside line 1
        n = 0;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 4; c++) begin
                tbl[n].v = 1'b1; tbl[n].sof = (l == 0 && c == 0); tbl[n].eol = (c == 3);
                tbl[n].d = pv(l, c);
                tbl[n].etap = 3'b001; tbl[n].edata = '0; tbl[n].emask = '0;
                tbl[n].edata[0 +: DSIZE] = pv(l, c);
                tbl[n].emask[0 +: DSIZE] = '1;
                for (int k = 1; k <= TAPS; k++) begin
                    if (l >= k) begin
                        tbl[n].etap[k] = 1'b1;
                        tbl[n].edata[k*DSIZE +: DSIZE] = pv(l - k, c);
                        tbl[n].emask[k*DSIZE +: DSIZE] = '1;
                    end
                end
                n++;
                if (l == 1 && c == 1) begin
                    tbl[n] = '{default: '0};
                    n++;
                end
            end
        end

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", {vif.out_valid, vif.out_sof, vif.out_eol, vif.out_tap_vld}, '0);
        chk("rst_data", vif.out_data, '0);
        chk("rst_status", {vif.ram_wr_en, vif.ram_wr_addr, vif.line_len, vif.line_err, vif.ram_rd_en}, '0);
        rst_n = 1'b1;

        // IDLE drops pixels without sof
        mon_en = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'(i & 1), DSIZE'($urandom));
        idle(2);
        chk("idle_no_out", out_cnt - base, 0);

        // latency of a single sof pixel
        drive(1'b1, 1'b1, 1'b0, 24'hABCDEF);
        chk("lat_t1", {vif.ram_wr_en, vif.ram_wr_addr, vif.out_valid}, {1'b1, 3'd0, 1'b0});
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("lat_t2", {vif.out_valid, vif.out_sof, vif.ram_wr_en, vif.out_data[DSIZE-1:0]},
            {1'b1, 1'b1, 1'b0, 24'hABCDEF});
        idle(2);
        mon_en = 1'b0;

        // table-driven frame
        for (int i = 0; i < NT + 2; i++) begin
            if (i >= 2) begin
                t = tbl[i-2];
                if (t.v)
                    chk("tbl_out", {vif.out_valid, vif.out_tap_vld, vif.out_sof, vif.out_eol, vif.out_data & t.emask},
                        {1'b1, t.etap, t.sof, t.eol, t.edata & t.emask});
                else
                    chk("tbl_bubble", vif.out_valid, 1'b0);
            end
            if (i < NT) drive(tbl[i].v, tbl[i].sof, tbl[i].eol, tbl[i].d);
            else        drive(1'b0, 1'b0, 1'b0, '0);
        end
        chk("tbl_status", {vif.line_len, vif.line_err}, {4'd4, 1'b0});
        sb.delete();

        // second sof mid-frame
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 24'h000111);
        drive(1'b1, 1'b0, 1'b0, 24'h000222);
        drive(1'b1, 1'b1, 1'b0, 24'h000333);
        drive(1'b1, 1'b0, 1'b1, 24'h000444);
        chk("resof_tap", {vif.out_sof, vif.out_tap_vld}, {1'b1, 3'b001});
        idle(3);

        // 9-pixel line wraps col and flags error
        for (int c = 0; c < 9; c++) drive(1'b1, 1'(c == 0), 1'(c == 8), DSIZE'($urandom));
        idle(3);
        chk("wrap_status", {vif.line_len, vif.line_err}, {4'd9, 1'b1});
        drive(1'b1, 1'b1, 1'b0, 24'h0000AA);
        drive(1'b1, 1'b0, 1'b1, 24'h0000BB);
        idle(3);
        chk("sof_clears_err", {vif.line_len, vif.line_err}, {4'd2, 1'b0});
        drive(1'b1, 1'b0, 1'b1, 24'h0000CC);
        idle(3);
        chk("one_px_line", {vif.line_len, vif.line_err}, {4'd1, 1'b1});

        // gap-free full-length lines
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < NCOL; c++)
                drive(1'b1, 1'(l == 0 && c == 0), 1'(c == NCOL - 1), DSIZE'($urandom));
        idle(3);
        chk("full_status", {vif.line_len, vif.line_err}, {4'd8, 1'b0});

        // randomized frames with bubbles and truncated last lines
        o0 = out_cnt; a0 = acc_cnt;
        for (int f = 0; f < 25; f++) begin
            len   = $urandom_range(2, NCOL);
            nl    = $urandom_range(1, 4);
            trunc = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < nl; l++) begin
                lim = (trunc && l == nl - 1) ? len / 2 : len;
                for (int c = 0; c < lim; c++) begin
                    while ($urandom_range(0, 3) == 0)
                        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DSIZE'($urandom));
                    drive(1'b1, 1'(l == 0 && c == 0), 1'(c == len - 1), DSIZE'($urandom));
                end
            end
        end
        idle(3);
        chk("rand_count", out_cnt - o0, acc_cnt - a0);

        // asynchronous reset mid-line
        drive(1'b1, 1'b1, 1'b0, 24'h00F001);
        drive(1'b1, 1'b0, 1'b0, 24'h00F002);
        drive(1'b1, 1'b0, 1'b0, 24'h00F003);
        drive(1'b1, 1'b0, 1'b0, 24'h00F004);
        chk("pre_rst_valid", vif.out_valid, 1'b1);
        vif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {vif.out_valid, vif.out_sof, vif.out_eol, vif.out_tap_vld, vif.ram_wr_en,
                          vif.line_len, vif.line_err}, '0);
        chk("async_rst_data", vif.out_data, '0);
        sb.delete();
        model_reset();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, DSIZE'($urandom));
        idle(2);
        chk("post_rst_no_out", out_cnt - base, 0);
        drive(1'b1, 1'b1, 1'b0, 24'h00E001);
        idle(3);
        chk("post_rst_sof_out", out_cnt - base, 1);

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
